// File: rtl/xb_mem32_pkg.sv
// Shared widths and prefetch entry type for the mem_32 bank.
// No logic, so no latency; no flow control.
// Prefetch entries carry their source address, so a host write can rewind the read pointer.
package xb_mem32_pkg;
    localparam int XB_MEM32_DATA_W    = 32;
    localparam int XB_MEM32_ADDR_IN_W = 16;
    localparam int XB_MEM32_PF_DEPTH  = 2;

    typedef struct packed {
        logic [XB_MEM32_DATA_W-1:0]    data;
        logic [XB_MEM32_ADDR_IN_W-1:0] addr;
    } xb_pf_entry_t;
endpackage

// File: rtl/xb_mem32_ram.sv
// Inferred word RAM with registered reads. Port B exists only with XB_MEM32_FABRIC_PORT_EN.
// Read latency is 1 cycle. Writes never stall and there is no backpressure.
// When both ports write the same address in one cycle, port A is kept and port B is dropped.
module xb_mem32_ram
    import xb_mem32_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_a_we,
    input  logic                       i_a_re,
    input  logic [ADDR_W-1:0]          i_a_addr,
    input  logic [XB_MEM32_DATA_W-1:0] i_a_wdata,
    output logic [XB_MEM32_DATA_W-1:0] o_a_rdata
`ifdef XB_MEM32_FABRIC_PORT_EN
    ,
    input  logic                       i_b_we,
    input  logic                       i_b_re,
    input  logic [ADDR_W-1:0]          i_b_addr,
    input  logic [XB_MEM32_DATA_W-1:0] i_b_wdata,
    output logic [XB_MEM32_DATA_W-1:0] o_b_rdata
`endif
);
    logic [XB_MEM32_DATA_W-1:0] r_mem [2**ADDR_W];
    logic [XB_MEM32_DATA_W-1:0] r_a_rdata;

    always_ff @(posedge i_clk) begin
`ifdef XB_MEM32_FABRIC_PORT_EN
        if (i_b_we && !(i_a_we && (i_a_addr == i_b_addr)))
            r_mem[i_b_addr] <= i_b_wdata;
`endif
        if (i_a_we)
            r_mem[i_a_addr] <= i_a_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_a_rdata <= '0;
        else if (i_a_re)
            r_a_rdata <= r_mem[i_a_addr];
    end
    assign o_a_rdata = r_a_rdata;

`ifdef XB_MEM32_FABRIC_PORT_EN
    logic [XB_MEM32_DATA_W-1:0] r_b_rdata;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_b_rdata <= '0;
        else if (i_b_re)
            r_b_rdata <= r_mem[i_b_addr];
    end
    assign o_b_rdata = r_b_rdata;
`endif
endmodule

// File: rtl/xillybus_mem32_bank.sv
// Seekable Xillybus mem_32 bank: auto-incrementing write pointer and a 2-entry read prefetch.
// Seek to first word takes 2 cycles, then 1 word per cycle. Host writes never stall.
// The host read side signals backpressure through empty. XB_MEM32_FABRIC_PORT_EN adds a fabric port with a 1-cycle read.
module xillybus_mem32_bank
    import xb_mem32_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                          bus_clk,
    input  logic                          bus_rstn,
    input  logic                          user_w_mem_32_wren,
    input  logic [XB_MEM32_DATA_W-1:0]    user_w_mem_32_data,
    output logic                          user_w_mem_32_full,
    input  logic                          user_w_mem_32_open,
    input  logic                          user_r_mem_32_rden,
    output logic [XB_MEM32_DATA_W-1:0]    user_r_mem_32_data,
    output logic                          user_r_mem_32_empty,
    output logic                          user_r_mem_32_eof,
    input  logic                          user_r_mem_32_open,
    input  logic [XB_MEM32_ADDR_IN_W-1:0] user_mem_32_addr,
    input  logic                          user_mem_32_addr_update
`ifdef XB_MEM32_FABRIC_PORT_EN
    ,
    input  logic [ADDR_W-1:0]             fab_addr,
    input  logic                          fab_rd,
    output logic [XB_MEM32_DATA_W-1:0]    fab_rdata,
    output logic                          fab_rvalid,
    input  logic                          fab_wr,
    input  logic [XB_MEM32_DATA_W-1:0]    fab_wdata
`endif
);
    logic [ADDR_W-1:0]          r_wr_ptr, r_rd_ptr, r_inflight_addr;
    xb_pf_entry_t               r_pf [XB_MEM32_PF_DEPTH];
    logic [1:0]                 r_count;
    logic                       r_inflight;
    logic                       r_rd_open_q;

    logic [ADDR_W-1:0]          w_seek_addr, w_wr_addr, w_rewind;
    logic                       w_pop, w_close, w_flush, w_issue;
    logic [1:0]                 w_count_pp;
    logic [XB_MEM32_DATA_W-1:0] w_ram_rdata;
    xb_pf_entry_t               w_new;
    logic                       w_unused;

    assign w_seek_addr = user_mem_32_addr[ADDR_W-1:0];
    assign w_wr_addr   = user_mem_32_addr_update ? w_seek_addr : r_wr_ptr;
    assign w_pop       = user_r_mem_32_rden && (r_count != 2'd0);
    assign w_close     = r_rd_open_q && !user_r_mem_32_open;
    assign w_flush     = user_mem_32_addr_update || user_w_mem_32_wren || w_close;
    // Occupancy is taken after this cycle's pop, so continuous popping never starves the prefetch.
    assign w_count_pp  = r_count - {1'b0, w_pop};
    assign w_issue     = (({1'b0, w_count_pp} + {2'b00, r_inflight}) < 3'd2)
                         && user_r_mem_32_open && !w_flush;
    assign w_new       = '{data: w_ram_rdata, addr: XB_MEM32_ADDR_IN_W'(r_inflight_addr)};

    // Oldest word the host has not consumed yet, once this cycle's pop is applied.
    always_comb begin
        w_rewind = r_rd_ptr;
        if (w_count_pp != 2'd0)
            w_rewind = w_pop ? r_pf[1].addr[ADDR_W-1:0] : r_pf[0].addr[ADDR_W-1:0];
        else if (r_inflight)
            w_rewind = r_inflight_addr;
    end

    always_ff @(posedge bus_clk or negedge bus_rstn) begin
        if (!bus_rstn) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_inflight_addr <= '0;
            r_count         <= '0;
            r_inflight      <= 1'b0;
            r_rd_open_q     <= 1'b0;
            for (int i = 0; i < XB_MEM32_PF_DEPTH; i++)
                r_pf[i] <= '0;
        end else begin
            r_rd_open_q <= user_r_mem_32_open;
            if (user_w_mem_32_wren)
                r_wr_ptr <= w_wr_addr + 1'b1;
            else if (user_mem_32_addr_update)
                r_wr_ptr <= w_seek_addr;

            if (w_flush) begin
                r_count    <= '0;
                r_inflight <= 1'b0;
                if (user_mem_32_addr_update)
                    r_rd_ptr <= w_seek_addr;
                else if (user_w_mem_32_wren)
                    r_rd_ptr <= w_rewind;
            end else begin
                if (w_pop)
                    r_pf[0] <= r_pf[1];
                if (r_inflight) begin
                    if (w_count_pp == 2'd0)
                        r_pf[0] <= w_new;
                    else
                        r_pf[1] <= w_new;
                end
                r_count    <= w_count_pp + {1'b0, r_inflight};
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_addr <= r_rd_ptr;
                    r_rd_ptr        <= r_rd_ptr + 1'b1;
                end
            end
        end
    end

    xb_mem32_ram #(.ADDR_W(ADDR_W)) u_ram (
        .i_clk     (bus_clk),
        .i_rst_n   (bus_rstn),
        .i_a_we    (user_w_mem_32_wren),
        .i_a_re    (w_issue),
        .i_a_addr  (user_w_mem_32_wren ? w_wr_addr : r_rd_ptr),
        .i_a_wdata (user_w_mem_32_data),
        .o_a_rdata (w_ram_rdata)
`ifdef XB_MEM32_FABRIC_PORT_EN
        ,
        .i_b_we    (fab_wr),
        .i_b_re    (fab_rd),
        .i_b_addr  (fab_addr),
        .i_b_wdata (fab_wdata),
        .o_b_rdata (fab_rdata)
`endif
    );

`ifdef XB_MEM32_FABRIC_PORT_EN
    logic r_fab_rvalid;
    always_ff @(posedge bus_clk or negedge bus_rstn) begin
        if (!bus_rstn)
            r_fab_rvalid <= 1'b0;
        else
            r_fab_rvalid <= fab_rd;
    end
    assign fab_rvalid = r_fab_rvalid;
`endif

    assign user_r_mem_32_data  = r_pf[0].data;
    assign user_r_mem_32_empty = (r_count == 2'd0);
    assign user_w_mem_32_full  = 1'b0;
    assign user_r_mem_32_eof   = 1'b0;
    assign w_unused = ^{user_w_mem_32_open, user_mem_32_addr, r_pf[0].addr, r_pf[1].addr};
endmodule

// File: tb/tb_xillybus_mem32_bank.sv
// Directed and random checks of xillybus_mem32_bank against a word-level host-view model.
// The model is a memory array plus write and next-read addresses.
module tb_xillybus_mem32_bank;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        bus_clk = 1'b0;
    logic        bus_rstn;
    logic        user_w_mem_32_wren, user_w_mem_32_full, user_w_mem_32_open;
    logic [31:0] user_w_mem_32_data, user_r_mem_32_data;
    logic        user_r_mem_32_rden, user_r_mem_32_empty, user_r_mem_32_eof, user_r_mem_32_open;
    logic [15:0] user_mem_32_addr;
    logic        user_mem_32_addr_update;
`ifdef XB_MEM32_FABRIC_PORT_EN
    logic [AW-1:0] fab_addr;
    logic          fab_rd, fab_rvalid, fab_wr;
    logic [31:0]   fab_rdata, fab_wdata;
`endif

    always #5 bus_clk = ~bus_clk;

    xillybus_mem32_bank #(.ADDR_W(AW)) dut (
        .bus_clk                 (bus_clk),
        .bus_rstn                (bus_rstn),
        .user_w_mem_32_wren      (user_w_mem_32_wren),
        .user_w_mem_32_data      (user_w_mem_32_data),
        .user_w_mem_32_full      (user_w_mem_32_full),
        .user_w_mem_32_open      (user_w_mem_32_open),
        .user_r_mem_32_rden      (user_r_mem_32_rden),
        .user_r_mem_32_data      (user_r_mem_32_data),
        .user_r_mem_32_empty     (user_r_mem_32_empty),
        .user_r_mem_32_eof       (user_r_mem_32_eof),
        .user_r_mem_32_open      (user_r_mem_32_open),
        .user_mem_32_addr        (user_mem_32_addr),
        .user_mem_32_addr_update (user_mem_32_addr_update)
`ifdef XB_MEM32_FABRIC_PORT_EN
        ,
        .fab_addr                (fab_addr),
        .fab_rd                  (fab_rd),
        .fab_rdata               (fab_rdata),
        .fab_rvalid              (fab_rvalid),
        .fab_wr                  (fab_wr),
        .fab_wdata               (fab_wdata)
`endif
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_mem [DEPTH];
    int          m_wr = 0;
    int          m_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge bus_clk);
        @(negedge bus_clk);
    endtask

    task automatic host_write(input logic [31:0] d);
        user_w_mem_32_wren = 1'b1;
        user_w_mem_32_data = d;
        m_mem[m_wr] = d;
        m_wr = (m_wr + 1) % DEPTH;
        tick();
        user_w_mem_32_wren = 1'b0;
    endtask

    // Upper address bits are randomised; the DUT must ignore them.
    task automatic seek(input int a);
        user_mem_32_addr_update = 1'b1;
        user_mem_32_addr = {12'($urandom), 4'(a)};
        m_wr = a;
        m_rd = a;
        tick();
        user_mem_32_addr_update = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 8 && user_r_mem_32_empty; i++) tick();
        chk({tag, "_ready"}, 32'(user_r_mem_32_empty), 32'd0);
    endtask

    // Caller holds rden high; checks the head word and consumes it.
    task automatic pop_check(input string tag);
        chk({tag, "_nonempty"}, 32'(user_r_mem_32_empty), 32'd0);
        chk(tag, user_r_mem_32_data, m_mem[m_rd]);
        m_rd = (m_rd + 1) % DEPTH;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n_pops;
        logic [31:0] d;
        logic        do_seek, do_wr, do_rd;
        int          a;

        bus_rstn = 1'b0;
        user_w_mem_32_wren = 0; user_w_mem_32_data = 0; user_w_mem_32_open = 1;
        user_r_mem_32_rden = 0; user_r_mem_32_open = 0;
        user_mem_32_addr = 0; user_mem_32_addr_update = 0;
`ifdef XB_MEM32_FABRIC_PORT_EN
        fab_addr = 0; fab_rd = 0; fab_wr = 0; fab_wdata = 0;
`endif
        @(negedge bus_clk);
        @(negedge bus_clk);
        chk("rst_empty", 32'(user_r_mem_32_empty), 32'd1);
        chk("rst_data", user_r_mem_32_data, 32'd0);
        chk("rst_full", 32'(user_w_mem_32_full), 32'd0);
        chk("rst_eof", 32'(user_r_mem_32_eof), 32'd0);
`ifdef XB_MEM32_FABRIC_PORT_EN
        chk("rst_fab_rvalid", 32'(fab_rvalid), 32'd0);
        chk("rst_fab_rdata", fab_rdata, 32'd0);
`endif
        bus_rstn = 1'b1;
        tick();

        // Fill the whole memory while the read stream is closed.
        for (int i = 0; i < DEPTH; i++)
            host_write(i < 4 ? 32'hA0 + 32'(i) : $urandom);
        chk("full_never", 32'(user_w_mem_32_full), 32'd0);

`ifdef XB_MEM32_FABRIC_PORT_EN
        fab_rd = 1; fab_addr = 4'd3;
        tick();
        fab_rd = 0;
        chk("fab_rvalid", 32'(fab_rvalid), 32'd1);
        chk("fab_rdata3", fab_rdata, 32'hA3);
        tick();
        chk("fab_rvalid_pulse", 32'(fab_rvalid), 32'd0);
`endif

        // Seek latency and streaming readback.
        user_r_mem_32_open = 1;
        seek(0);
        chk("seek_lat_e0", 32'(user_r_mem_32_empty), 32'd1);
        tick();
        chk("seek_lat_e1", 32'(user_r_mem_32_empty), 32'd1);
        tick();
        chk("seek_lat_e2", 32'(user_r_mem_32_empty), 32'd0);
        user_r_mem_32_rden = 1;
        for (int i = 0; i < 4; i++) begin
            chk("stream_const", user_r_mem_32_data, 32'hA0 + 32'(i));
            pop_check("stream");
        end
        user_r_mem_32_rden = 0;

        // Wrap-around at the top of the address space.
        seek(15);
        host_write(32'h11);
        host_write(32'h22);
        seek(15);
        wait_ready("wrap");
        user_r_mem_32_rden = 1;
        chk("wrap_0x11", user_r_mem_32_data, 32'h11);
        pop_check("wrap_a15");
        chk("wrap_0x22", user_r_mem_32_data, 32'h22);
        pop_check("wrap_a0");
        user_r_mem_32_rden = 0;

        // A host write must invalidate stale prefetched words.
        seek(5);
        host_write($urandom);
        repeat (4) tick();
        chk("inv_full", 32'(user_r_mem_32_empty), 32'd0);
        user_r_mem_32_rden = 1;
        pop_check("inv_pop5");
        user_r_mem_32_rden = 0;
        host_write(32'hBEEF);
        chk("inv_flush", 32'(user_r_mem_32_empty), 32'd1);
        wait_ready("inv");
        chk("inv_beef_const", user_r_mem_32_data, 32'hBEEF);
        user_r_mem_32_rden = 1;
        pop_check("inv_beef");
        user_r_mem_32_rden = 0;

        // Seek with a same-cycle pop on a full buffer.
        repeat (3) tick();
        user_r_mem_32_rden = 1;
        seek(2);
        user_r_mem_32_rden = 0;
        chk("mid_seek_e0", 32'(user_r_mem_32_empty), 32'd1);
        tick();
        chk("mid_seek_e1", 32'(user_r_mem_32_empty), 32'd1);
        tick();
        user_r_mem_32_rden = 1;
        pop_check("mid_seek_a2");
        pop_check("mid_seek_a3");
        user_r_mem_32_rden = 0;

        // Reads while empty are ignored.
        user_r_mem_32_open = 0;
        tick();
        seek(9);
        user_r_mem_32_rden = 1;
        for (int i = 0; i < 5; i++) begin
            chk("empty_rden", 32'(user_r_mem_32_empty), 32'd1);
            tick();
        end
        user_r_mem_32_rden = 0;
        user_r_mem_32_open = 1;
        wait_ready("reopen");
        user_r_mem_32_rden = 1;
        pop_check("reopen_a9");
        user_r_mem_32_rden = 0;

`ifdef XB_MEM32_FABRIC_PORT_EN
        seek(7);
        user_w_mem_32_wren = 1; user_w_mem_32_data = 32'h1234;
        fab_wr = 1; fab_addr = 4'd7; fab_wdata = 32'h5555;
        m_mem[7] = 32'h1234;
        m_wr = 8;
        tick();
        user_w_mem_32_wren = 0; fab_wr = 0;
        fab_rd = 1; fab_addr = 4'd7;
        tick();
        fab_rd = 0;
        chk("collide_host_wins", fab_rdata, 32'h1234);
        d = $urandom;
        fab_wr = 1; fab_addr = 4'd12; fab_wdata = d;
        m_mem[12] = d;
        tick();
        fab_wr = 0;
`endif

        // Random mix of seeks, writes and pops against the model.
        seek(int'($urandom_range(0, DEPTH - 1)));
        n_pops = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            do_seek = ($urandom % 20) == 0;
            do_wr   = ($urandom % 5) == 0;
            do_rd   = ($urandom % 4) != 0;
            d = $urandom;
            a = int'($urandom_range(0, DEPTH - 1));
            if (do_rd && !user_r_mem_32_empty && !do_seek) begin
                chk("rand_pop", user_r_mem_32_data, m_mem[m_rd]);
                m_rd = (m_rd + 1) % DEPTH;
                n_pops++;
            end
            if (do_seek) begin
                m_rd = a;
                m_wr = a;
            end
            if (do_wr) begin
                m_mem[m_wr] = d;
                m_wr = (m_wr + 1) % DEPTH;
            end
            user_r_mem_32_rden      = do_rd;
            user_w_mem_32_wren      = do_wr;
            user_w_mem_32_data      = d;
            user_mem_32_addr_update = do_seek;
            user_mem_32_addr        = {12'($urandom), 4'(a)};
            tick();
        end
        user_r_mem_32_rden = 0; user_w_mem_32_wren = 0; user_mem_32_addr_update = 0;
        chk("rand_progress", 32'(n_pops > 100), 32'd1);

        // Asynchronous reset in the middle of streaming.
        wait_ready("pre_reset");
        user_r_mem_32_rden = 1;
        #1 bus_rstn = 1'b0;
        #1;
        chk("mid_rst_empty", 32'(user_r_mem_32_empty), 32'd1);
        chk("mid_rst_data", user_r_mem_32_data, 32'd0);
`ifdef XB_MEM32_FABRIC_PORT_EN
        chk("mid_rst_fab_rvalid", 32'(fab_rvalid), 32'd0);
`endif
        user_r_mem_32_rden = 0;
        tick();
        bus_rstn = 1'b1;
        m_rd = 0;
        m_wr = 0;
        tick();
        wait_ready("post_reset");
        user_r_mem_32_rden = 1;
        pop_check("post_reset_a0");
        user_r_mem_32_rden = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
